// File: rtl/bus_mem_responder_pkg.sv
// Shared codes for the memory-side bus responder.
// State encodings, op codes and counter width.
package bus_mem_responder_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE    = 2'd0,
    RSP_WAIT    = 2'd1,
    RSP_RESP    = 2'd2,
    RSP_RELEASE = 2'd3
  } rsp_state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/bus_mem_responder_mem_array.sv
// Single-port synchronous word RAM, registered read.
// Read data appears on the edge after an enabled read.
module resp_mem_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory responder for the shared request bus.
// Wait-state FSM, window range check and word array.
import bus_mem_responder_pkg::*;

module bus_mem_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_LOG2  = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              read_q,
  input  logic              write_q,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_en,
  output logic              read_dn,
  output logic              write_dn,
  output logic              is_bus_busy,
  output logic              bus_err
);

  localparam logic [CNT_W-1:0] WAIT_LD =
    CNT_W'(WAIT_CYCLES);

  rsp_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              rd_dn_q, rd_dn_d;
  logic              wr_dn_q, wr_dn_d;
  logic              oe_q, oe_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              ram_en, ram_we;
  logic [DATA_W-1:0] ram_q;

  // Wrap below the base yields a huge idx, so it fails the check.
  assign idx      = addr_q - BASE_ADDR;
  assign in_range = (idx >> DEPTH_LOG2) == '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    rd_dn_d = 1'b0;
    wr_dn_d = 1'b0;
    oe_d    = 1'b0;
    err_d   = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    if (clk_oe) begin
      unique case (state_q)
        RSP_IDLE: begin
          if (read_q && write_q) begin
            err_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = RSP_RELEASE;
          end else if (read_q || write_q) begin
            op_d   = write_q ? OP_WR : OP_RD;
            addr_d = addr_in;
            if (write_q) wdata_d = data_in;
            cnt_d  = WAIT_LD;
            busy_d = 1'b1;
            state_d = (WAIT_LD == '0) ?
                      RSP_RESP : RSP_WAIT;
          end
        end
        RSP_WAIT: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= 1) state_d = RSP_RESP;
        end
        RSP_RESP: begin
          ram_en  = in_range && !rst;
          ram_we  = op_q == OP_WR;
          rd_dn_d = op_q == OP_RD;
          oe_d    = op_q == OP_RD;
          wr_dn_d = op_q == OP_WR;
          err_d   = !in_range;
          state_d = RSP_RELEASE;
        end
        RSP_RELEASE: begin
          if (!read_q && !write_q) begin
            busy_d  = 1'b0;
            state_d = RSP_IDLE;
          end
        end
        default: state_d = RSP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      rd_dn_q <= 1'b0;
      wr_dn_q <= 1'b0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      rd_dn_q <= rd_dn_d;
      wr_dn_q <= wr_dn_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
    end
  end

  resp_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_mem (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx[DEPTH_LOG2-1:0]),
    .wdata(wdata_q),
    .rdata(ram_q)
  );

  // An out-of-range read carries bus_err and must present zero.
  assign data_out    = (oe_q && !err_q) ? ram_q : '0;
  assign data_out_en = oe_q;
  assign read_dn     = rd_dn_q;
  assign write_dn    = wr_dn_q;
  assign is_bus_busy = busy_q;
  assign bus_err     = err_q;

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side responder for the shared CPU/dispatcher request bus. It answers the `read_q`/`write_q` requests issued by the per-CPU start, fetch and register-writeback managers, for example the IP read, command fetch and IP writeback of the start phase. It holds a parameterised word array mapped at a base window, inserts programmable wait states, and returns one-cycle `read_dn`/`write_dn` completions. It sits on the bus opposite the initiators, behind the dispatcher.

## Interface
- `ADDR_W`, default 32: address width (matches `ADDR_SIZE`).
- `DATA_W`, default 32: data width (matches `DATA_SIZE`).
- `DEPTH_LOG2`, default 10: log2 of the number of words in the array.
- `BASE_ADDR`, default 0: first word address of the window.
- `WAIT_CYCLES`, default 2: wait states inserted before completion, range 0..15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk_oe` in 1: bus phase. The block samples and acts only on edges where `clk_oe`=1.
- `read_q` in 1: read request.
- `write_q` in 1: write request.
- `addr_in` in `ADDR_W`: request word address.
- `data_in` in `DATA_W`: write data.
- `data_out` out `DATA_W`: read data. Valid only while `data_out_en`=1, 0 otherwise.
- `data_out_en` out 1: read data is driven this cycle.
- `read_dn` out 1: one-cycle read completion.
- `write_dn` out 1: one-cycle write completion.
- `is_bus_busy` out 1: high from request capture until release.
- `bus_err` out 1: one-cycle error flag, coincident with `dn` or issued alone.

## Operation
- States: IDLE, WAIT, RESP, RELEASE. All transitions happen only on edges with `clk_oe`=1.
- On `clk_oe`=0 edges, all state, counters and outputs hold, except the one-cycle pulses (`read_dn`, `write_dn`, `data_out_en`, `bus_err`), which clear to 0.
- IDLE, request capture:
  - `read_q`=1 xor `write_q`=1: latch `addr_in` and op; for a write, also latch `data_in`. Load the counter with `WAIT_CYCLES`, set `is_bus_busy`=1, go to WAIT (or directly to RESP if `WAIT_CYCLES`=0).
  - Both requests high: pulse `bus_err`, capture nothing, go to RELEASE with busy=1.
- Range check: `idx = (addr - BASE_ADDR)` computed modulo 2^`ADDR_W`. The address is in range iff `idx < 2^DEPTH_LOG2`, evaluated unsigned. A wrap below `BASE_ADDR` is therefore out of range.
- WAIT: decrement the counter; at 0, go to RESP.
- RESP, for one `clk_oe`=1 cycle:
  - Read in range: `data_out` = mem[idx], `data_out_en`=1, `read_dn`=1.
  - Read out of range: `data_out` = 0, `data_out_en`=1, `read_dn`=1, `bus_err`=1.
  - Write in range: mem[idx] is updated on this edge, `write_dn`=1.
  - Write out of range: no update, `write_dn`=1, `bus_err`=1.
  - Then go to RELEASE.
- RELEASE: stay until both `read_q` and `write_q` are sampled 0, then set `is_bus_busy`=0 and go to IDLE. A held request is never serviced twice.
- Requests that arrive outside IDLE are ignored. Initiators must wait for busy to drop.

## Timing
- Reset values: state IDLE, counter 0, every output 0. Array contents are not reset.
- Read latency: `read_dn` rises on the (`WAIT_CYCLES`+1)th `clk_oe`=1 edge after the capture edge. Write latency is the same. With `WAIT_CYCLES`=0 this is the next `clk_oe`=1 edge.
- `read_dn`, `write_dn`, `data_out_en` and `bus_err` are high for exactly one `clk` cycle.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- Reset mid-transaction aborts it: no `dn`, and no array write unless RESP had already completed.
- Minimum request-to-request spacing: capture, WAIT_CYCLES, RESP, then one RELEASE edge with requests low.

## Structure
- The shared package (`misc_codes.v`/`states.v` style) holds:
  - responder state encodings (`RSP_IDLE`, `RSP_WAIT`, `RSP_RESP`, `RSP_RELEASE`);
  - the op code constants (`OP_RD`, `OP_WR`);
  - the wait-counter width of 4.
- One sub-module: `resp_mem_array`, a single-port synchronous RAM with `DEPTH_LOG2`/`DATA_W` parameters, write enable, and registered read.
- The FSM, range check and counter stay in the top module.

## Test plan
- Reset, then with `BASE_ADDR`=0x100 and `WAIT_CYCLES`=2, write 0xDEADBEEF to 0x105 → `write_dn` on the 3rd `clk_oe` edge after capture; a following read of 0x105 → `read_dn` with `data_out`=0xDEADBEEF.
- Read 0x0FF (below base, wraps) → `read_dn`=1, `bus_err`=1, `data_out`=0.
- `read_q` and `write_q` both high in IDLE → `bus_err` pulse, no `dn`, and the array is unchanged at 0x100.
- `read_q` held high for 10 cycles → exactly one `read_dn`; `is_bus_busy` drops only after `read_q` falls.
- `WAIT_CYCLES`=0, `clk_oe` toggling every cycle → `dn` on the next `clk_oe`=1 edge after capture.
- Assert `rst` during WAIT of a write of 0x1234 to 0x101 → no `write_dn`, all outputs 0, and a later read of 0x101 returns the old value.
